// File: rtl/l7_branch_pkg.sv
// Shared opcode/counter constants and helper functions for the l7 branch unit.
package l7_branch_pkg;

   typedef logic [1:0] cnt_t;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_BZ   = 3'b001;
   localparam logic [2:0] OP_BNZ  = 3'b010;
   localparam logic [2:0] OP_BLTZ = 3'b011;
   localparam logic [2:0] OP_BGEZ = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;

   localparam cnt_t CNT_SNT   = 2'b00;
   localparam cnt_t CNT_WNT   = 2'b01;
   localparam cnt_t CNT_WT    = 2'b10;
   localparam cnt_t CNT_ST    = 2'b11;
   localparam cnt_t CNT_RESET = CNT_WNT;

   function automatic logic is_cond(input logic [2:0] op);
      case (op)
         OP_BZ, OP_BNZ, OP_BLTZ, OP_BGEZ: is_cond = 1'b1;
         default:                         is_cond = 1'b0;
      endcase
   endfunction

   // Operand is pre-reduced to zero/sign flags so the function stays width-agnostic.
   function automatic logic cond_taken(input logic [2:0] op, input logic data_zero,
                                       input logic data_sign);
      case (op)
         OP_BZ:   cond_taken = data_zero;
         OP_BNZ:  cond_taken = ~data_zero;
         OP_BLTZ: cond_taken = data_sign;
         OP_BGEZ: cond_taken = ~data_sign;
         OP_JMP:  cond_taken = 1'b1;
         default: cond_taken = 1'b0;
      endcase
   endfunction

   function automatic cnt_t sat_next(input cnt_t cnt, input logic taken);
      if (taken) begin
         sat_next = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
      end else begin
         sat_next = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
      end
   endfunction

endpackage

// File: rtl/l7_branch_unit_if.sv
// Lookup and resolve bus between fetch/execute (master) and the branch unit (slave).
interface l7_branch_unit_if #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16
);
   logic              lk_valid;
   logic [PC_W-1:0]   lk_pc;
   logic              pred_taken;
   logic              pred_valid;
   logic              rs_valid;
   logic [2:0]        rs_op;
   logic [PC_W-1:0]   rs_pc;
   logic [DATA_W-1:0] rs_data;
   logic              rs_pred;
   logic              branch;
   logic              mispredict;
   logic              rs_done;

   modport master (
      output lk_valid, lk_pc, rs_valid, rs_op, rs_pc, rs_data, rs_pred,
      input  pred_taken, pred_valid, branch, mispredict, rs_done
   );

   modport slave (
      input  lk_valid, lk_pc, rs_valid, rs_op, rs_pc, rs_data, rs_pred,
      output pred_taken, pred_valid, branch, mispredict, rs_done
   );
endinterface

// File: rtl/l7_bht.sv
// Direct-mapped table of 2-bit saturating counters: one registered read port,
// one write port, read-before-write on same-index collisions, reset to WNT.
module l7_bht
   import l7_branch_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rd_en,
   input  logic [IDX_W-1:0] i_rd_idx,
   output cnt_t             o_rd_cnt,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_taken
);
   localparam int DEPTH = 2 ** IDX_W;

   cnt_t r_table [DEPTH];
   cnt_t r_rd_cnt;

   // Counter storage with saturating update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_table[i] <= CNT_RESET;
         end
      end else if (i_wr_en) begin
         r_table[i_wr_idx] <= sat_next(r_table[i_wr_idx], i_wr_taken);
      end
   end

   // Read register; holds its value while no lookup is requested.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_cnt <= CNT_SNT;
      end else if (i_rd_en) begin
         r_rd_cnt <= r_table[i_rd_idx];
      end
   end

   assign o_rd_cnt = r_rd_cnt;
endmodule

// File: rtl/l7_branch_unit.sv
// Branch resolution and 2-bit counter prediction unit.
// Optional statistics counters are enabled by defining L7_BRANCH_STATS_EN.
module l7_branch_unit
   import l7_branch_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   l7_branch_unit_if.slave   bus
`ifdef L7_BRANCH_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispredicts
`endif
);
   logic w_zero;
   logic w_sign;
   logic w_cond;
   logic w_is_jmp;
   logic w_taken;
   logic w_branch;
   logic w_mispredict;
   cnt_t w_rd_cnt;

   logic r_pred_valid;
   logic r_branch;
   logic r_mispredict;
   logic r_rs_done;

   assign w_zero   = (bus.rs_data == {DATA_W{1'b0}});
   assign w_sign   = bus.rs_data[DATA_W-1];
   assign w_cond   = is_cond(bus.rs_op);
   assign w_is_jmp = (bus.rs_op == OP_JMP);
   assign w_taken  = cond_taken(bus.rs_op, w_zero, w_sign);

   // Only conditional ops and JMP can mispredict; NONE/invalid resolve quietly.
   always_comb begin
      w_branch     = 1'b0;
      w_mispredict = 1'b0;
      if (bus.rs_valid) begin
         w_branch     = w_taken;
         w_mispredict = (w_cond | w_is_jmp) & (w_taken ^ bus.rs_pred);
      end else begin
         w_branch     = 1'b0;
         w_mispredict = 1'b0;
      end
   end

   l7_bht #(.IDX_W(IDX_W)) u_bht (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_en    (bus.lk_valid),
      .i_rd_idx   (bus.lk_pc[IDX_W-1:0]),
      .o_rd_cnt   (w_rd_cnt),
      .i_wr_en    (bus.rs_valid & w_cond),
      .i_wr_idx   (bus.rs_pc[IDX_W-1:0]),
      .i_wr_taken (w_taken)
   );

   // Registered resolve results and lookup-valid flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pred_valid <= 1'b0;
         r_branch     <= 1'b0;
         r_mispredict <= 1'b0;
         r_rs_done    <= 1'b0;
      end else begin
         r_pred_valid <= bus.lk_valid;
         r_branch     <= w_branch;
         r_mispredict <= w_mispredict;
         r_rs_done    <= bus.rs_valid;
      end
   end

   assign bus.pred_taken = w_rd_cnt[1];
   assign bus.pred_valid = r_pred_valid;
   assign bus.branch     = r_branch;
   assign bus.mispredict = r_mispredict;
   assign bus.rs_done    = r_rs_done;

`ifdef L7_BRANCH_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Event counters, wrapping naturally at 2**32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_branches    <= 32'd0;
         r_stat_mispredicts <= 32'd0;
      end else begin
         if (bus.rs_valid && (w_cond || w_is_jmp)) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_l7_branch_unit.sv
// Directed plus random bench for l7_branch_unit with a reference counter model
// and an expectation queue; also checks stats when L7_BRANCH_STATS_EN is defined.
module tb_l7_branch_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   l7_branch_unit_if #(.DATA_W(16), .PC_W(16)) bus ();

   logic [31:0] stat_b;
   logic [31:0] stat_m;

   l7_branch_unit #(.DATA_W(16), .PC_W(16), .IDX_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef L7_BRANCH_STATS_EN
      ,
      .stat_branches    (stat_b),
      .stat_mispredicts (stat_m)
`endif
   );

   typedef struct {
      string       tag;
      logic        pv, pt, br, mp, dn;
      logic [31:0] sb, sm;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [1:0]  model [16];
   logic        last_pred;
   logic [31:0] m_sb, m_sm;

   function automatic logic tb_taken(input logic [2:0] op, input logic [15:0] d);
      case (op)
         3'b001:  return (d == 16'h0000);
         3'b010:  return (d != 16'h0000);
         3'b011:  return d[15];
         3'b100:  return !d[15];
         3'b101:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict outputs into the queue, then compare after the edge.
   task automatic step(input string tag, input logic rst, input logic lkv,
                       input logic [15:0] lkpc, input logic rsv, input logic [2:0] op,
                       input logic [15:0] pc, input logic [15:0] data, input logic pred);
      exp_t e;
      logic cond, tk;
      rst_n        = ~rst;
      bus.lk_valid = lkv;
      bus.lk_pc    = lkpc;
      bus.rs_valid = rsv;
      bus.rs_op    = op;
      bus.rs_pc    = pc;
      bus.rs_data  = data;
      bus.rs_pred  = pred;
      e.tag = tag;
      if (rst) begin
         e.pv = 1'b0; e.pt = 1'b0; e.br = 1'b0; e.mp = 1'b0; e.dn = 1'b0;
         for (int i = 0; i < 16; i++) model[i] = 2'b01;
         last_pred = 1'b0;
         m_sb = 32'd0;
         m_sm = 32'd0;
      end else begin
         if (lkv) last_pred = model[lkpc[3:0]][1];
         e.pv = lkv;
         e.pt = last_pred;
         cond = rsv && (op inside {3'b001, 3'b010, 3'b011, 3'b100});
         tk   = tb_taken(op, data);
         e.dn = rsv;
         e.br = rsv && tk;
         e.mp = rsv && (cond || op == 3'b101) && (tk != pred);
         if (rsv && (cond || op == 3'b101)) m_sb = m_sb + 32'd1;
         if (e.mp) m_sm = m_sm + 32'd1;
         if (cond) begin
            if (tk && model[pc[3:0]] != 2'b11) model[pc[3:0]] = model[pc[3:0]] + 2'd1;
            else if (!tk && model[pc[3:0]] != 2'b00) model[pc[3:0]] = model[pc[3:0]] - 2'd1;
         end
      end
      e.sb = m_sb;
      e.sm = m_sm;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk(tag, "queue_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         chk(e.tag, "pred_valid", {31'd0, bus.pred_valid}, {31'd0, e.pv});
         chk(e.tag, "pred_taken", {31'd0, bus.pred_taken}, {31'd0, e.pt});
         chk(e.tag, "branch",     {31'd0, bus.branch},     {31'd0, e.br});
         chk(e.tag, "mispredict", {31'd0, bus.mispredict}, {31'd0, e.mp});
         chk(e.tag, "rs_done",    {31'd0, bus.rs_done},    {31'd0, e.dn});
`ifdef L7_BRANCH_STATS_EN
         chk(e.tag, "stat_branches",    stat_b, e.sb);
         chk(e.tag, "stat_mispredicts", stat_m, e.sm);
`endif
      end
   endtask

   initial begin
      logic [15:0] rd;
      step("reset0", 1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("reset1", 1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("lk_init", 1'b0, 1'b1, 16'h0003, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("bz_a", 1'b0, 1'b0, 16'h0, 1'b1, 3'b001, 16'h0013, 16'h0000, 1'b0);
      step("bz_b", 1'b0, 1'b0, 16'h0, 1'b1, 3'b001, 16'h0013, 16'h0000, 1'b0);
      step("lk_alias", 1'b0, 1'b1, 16'h0003, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("bnz_nt", 1'b0, 1'b0, 16'h0, 1'b1, 3'b010, 16'h0007, 16'h0000, 1'b1);
      step("bnz_t", 1'b0, 1'b0, 16'h0, 1'b1, 3'b010, 16'h0007, 16'h8000, 1'b1);
      step("bltz_t", 1'b0, 1'b0, 16'h0, 1'b1, 3'b011, 16'h0008, 16'h8000, 1'b1);
      step("bgez_t", 1'b0, 1'b0, 16'h0, 1'b1, 3'b100, 16'h0009, 16'h7FFF, 1'b0);
      step("bltz_nt", 1'b0, 1'b0, 16'h0, 1'b1, 3'b011, 16'h0008, 16'h7FFF, 1'b1);
      step("bgez_nt", 1'b0, 1'b0, 16'h0, 1'b1, 3'b100, 16'h0009, 16'h8000, 1'b0);
      step("jmp", 1'b0, 1'b0, 16'h0, 1'b1, 3'b101, 16'h000A, 16'h1234, 1'b0);
      step("lk_jmp", 1'b0, 1'b1, 16'h000A, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("op110", 1'b0, 1'b0, 16'h0, 1'b1, 3'b110, 16'h000B, 16'h0000, 1'b1);
      step("op111", 1'b0, 1'b0, 16'h0, 1'b1, 3'b111, 16'h000B, 16'h0000, 1'b0);
      step("op_none", 1'b0, 1'b0, 16'h0, 1'b1, 3'b000, 16'h000B, 16'h0000, 1'b1);
      step("lk_hold", 1'b0, 1'b1, 16'h0003, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("idle", 1'b0, 1'b0, 16'h0004, 1'b0, 3'b001, 16'h0004, 16'h0000, 1'b1);
      for (int i = 0; i < 4; i++)
         step("sat_up", 1'b0, 1'b0, 16'h0, 1'b1, 3'b001, 16'h0005, 16'h0000, 1'b1);
      step("lk_sat", 1'b0, 1'b1, 16'h0005, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("rbw", 1'b0, 1'b1, 16'h0005, 1'b1, 3'b001, 16'h0005, 16'h0001, 1'b1);
      step("lk_after", 1'b0, 1'b1, 16'h0005, 1'b1, 3'b001, 16'h0005, 16'h0001, 1'b1);
      step("lk_wnt", 1'b0, 1'b1, 16'h0005, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("rst_mid", 1'b1, 1'b1, 16'h0003, 1'b1, 3'b001, 16'h0003, 16'h0000, 1'b0);
      step("lk_rst3", 1'b0, 1'b1, 16'h0003, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      step("st_a", 1'b0, 1'b0, 16'h0, 1'b1, 3'b001, 16'h0001, 16'h0000, 1'b1);
      step("st_b", 1'b0, 1'b0, 16'h0, 1'b1, 3'b010, 16'h0002, 16'h0005, 1'b1);
      step("st_c", 1'b0, 1'b0, 16'h0, 1'b1, 3'b011, 16'h0003, 16'h0005, 1'b1);
      step("st_idle", 1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       rd = 16'h0000;
            1:       rd = 16'h8000;
            2:       rd = 16'h7FFF;
            default: rd = 16'($urandom);
         endcase
         step("rand", 1'b0, 1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
              rd, 1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
